// File: rtl/memmap_ctrl_if.sv
// +--------------------------------------------------------------------+
// | memmap_ctrl_if                                                       |
// | CPU-side and device-side bus bundle of the memory-map controller.   |
// | slave  : the controller view (takes CPU requests, drives devices).  |
// | master : the environment view (CPU core plus memories/peripherals). |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
`default_nettype none

interface memmap_ctrl_if #(
  parameter int AW   = 16,
  parameter int DW   = 8,
  parameter int NREG = 3
) ();

  // CPU side
  logic               cpu_req;
  logic [AW-1:0]      cpu_a;
  logic [DW-1:0]      cpu_o;
  logic               cpu_w;
  logic [DW-1:0]      cpu_i;
  logic               cpu_ready;
  logic               bus_err;

  // Device side
  logic [NREG-1:0]    dev_sel;
  logic [AW-1:0]      dev_a;
  logic [DW-1:0]      dev_d;
  logic               dev_we;
  logic [NREG*DW-1:0] dev_q;

  modport slave (
    input  cpu_req, cpu_a, cpu_o, cpu_w,
    output cpu_i, cpu_ready, bus_err,
    output dev_sel, dev_a, dev_d, dev_we,
    input  dev_q
  );

  modport master (
    output cpu_req, cpu_a, cpu_o, cpu_w,
    input  cpu_i, cpu_ready, bus_err,
    input  dev_sel, dev_a, dev_d, dev_we,
    output dev_q
  );

endinterface

`default_nettype wire

// File: rtl/memmap_ctrl.sv
// +--------------------------------------------------------------------+
// | memmap_ctrl                                                          |
// | Memory-map controller: decodes a CPU access against NREG address    |
// | regions (lowest index wins), applies per-region wait states, drives |
// | a one-hot device select and returns read data with a ready pulse.   |
// | Unmapped accesses raise a one-cycle bus_err alongside cpu_ready.    |
// | Optional feature macro: MEMMAP_WPROT_EN (write protection of        |
// | regions flagged in REG_RO; when undefined REG_RO is ignored).       |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
`default_nettype none

module memmap_ctrl #(
  parameter int                   AW       = 16,
  parameter int                   DW       = 8,
  parameter int                   NREG     = 3,
  parameter logic [NREG*AW-1:0]   REG_BASE = {16'hB800, 16'h0000, 16'hE000},
  parameter logic [NREG*AW-1:0]   REG_MASK = {16'hF800, 16'hF000, 16'hE000},
  parameter logic [NREG*4-1:0]    REG_WS   = {4'd2, 4'd0, 4'd1},
  parameter logic [NREG-1:0]      REG_RO   = 3'b001,
  parameter logic [DW-1:0]        FILL     = 8'h00
) (
  input  wire          clk,
  input  wire          rst,
  memmap_ctrl_if.slave bus
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      wc;        // remaining wait states in ACCESS
  logic [IW-1:0]   idx;       // latched region index
  logic            wr;        // latched direction
  logic            prot_err;  // latched write-protect violation

  // Decoder results for the current CPU address
  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic [NREG-1:0] hit_sel;
  logic [AW-1:0]   hit_mask;
  logic [3:0]      hit_ws;
  logic            hit_prot;
  logic [DW-1:0]   rdata;

  // Priority decode: scan from the top so the lowest matching index is kept last
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_sel  = '0;
    hit_mask = '0;
    hit_ws   = '0;
    hit_prot = 1'b0;
    for (int r = NREG - 1; r >= 0; r--) begin
      if ((bus.cpu_a & REG_MASK[r*AW +: AW]) == REG_BASE[r*AW +: AW]) begin
        hit        = 1'b1;
        hit_idx    = IW'(r);
        hit_sel    = '0;
        hit_sel[r] = 1'b1;
        hit_mask   = REG_MASK[r*AW +: AW];
        hit_ws     = REG_WS[r*4 +: 4];
`ifdef MEMMAP_WPROT_EN
        hit_prot   = bus.cpu_w & REG_RO[r];
`else
        hit_prot   = 1'b0;
`endif
      end
    end
  end

`ifndef MEMMAP_WPROT_EN
  // Read-only attributes have no effect without write protection
  logic unused_ro;
  assign unused_ro = ^REG_RO;
`endif

  // Select the read data lane of the latched region
  always_comb begin
    rdata = '0;
    for (int r = 0; r < NREG; r++) begin
      if (idx == IW'(r)) begin
        rdata = bus.dev_q[r*DW +: DW];
      end
    end
  end

  // Access sequencer: every output is a register, dev_we/cpu_ready/bus_err
  // are cleared by default so they only ever last one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wc            <= '0;
      idx           <= '0;
      wr            <= 1'b0;
      prot_err      <= 1'b0;
      bus.cpu_i     <= '0;
      bus.cpu_ready <= 1'b0;
      bus.bus_err   <= 1'b0;
      bus.dev_sel   <= '0;
      bus.dev_a     <= '0;
      bus.dev_d     <= '0;
      bus.dev_we    <= 1'b0;
    end else begin
      bus.cpu_ready <= 1'b0;
      bus.bus_err   <= 1'b0;
      bus.dev_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            wr        <= bus.cpu_w;
            bus.dev_d <= bus.cpu_o;
            bus.dev_a <= bus.cpu_a & ~hit_mask;
            if (hit) begin
              idx         <= hit_idx;
              bus.dev_sel <= hit_sel;
              wc          <= hit_ws;
              prot_err    <= hit_prot;
              // With no wait states the first ACCESS cycle is also the last
              bus.dev_we  <= bus.cpu_w && (hit_ws == 4'd0) && !hit_prot;
              state       <= ACCESS;
            end else begin
              prot_err      <= 1'b0;
              bus.cpu_ready <= 1'b1;
              bus.bus_err   <= 1'b1;
              if (!bus.cpu_w) begin
                bus.cpu_i <= FILL;
              end
              state <= DONE;
            end
          end
        end

        ACCESS: begin
          if (wc != 4'd0) begin
            wc <= wc - 4'd1;
            // Arm the strobe so it lands on the final ACCESS cycle
            if ((wc == 4'd1) && wr && !prot_err) begin
              bus.dev_we <= 1'b1;
            end
          end else begin
            if (!wr) begin
              bus.cpu_i <= rdata;
            end
            bus.dev_sel   <= '0;
            bus.cpu_ready <= 1'b1;
            bus.bus_err   <= prot_err;
            state         <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state       <= IDLE;
          bus.dev_sel <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memmap_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_memmap_ctrl                                                       |
// | Directed, table-driven bench for memmap_ctrl with hand sequences    |
// | for back-to-back requests and reset during an access.               |
// | Honours MEMMAP_WPROT_EN when choosing expected values.              |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_memmap_ctrl;

  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int NREG = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  memmap_ctrl_if #(.AW(AW), .DW(DW), .NREG(NREG)) bus ();

  memmap_ctrl #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  o;
    logic        w;
    logic [23:0] q;     // {region2, region1, region0}
    int          lat;   // cycles from request to cpu_ready
    logic [2:0]  sel;
    logic [15:0] ea;
    logic [7:0]  ei;
    logic        err;
    logic        we;
  } vec_t;

  vec_t v[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen_we;
    int seen_rdy;

    //            a         o      w     q             lat sel     ea        ei     err   we
    v[0]  = '{16'hE123, 8'h00, 1'b0, 24'h11225A, 3, 3'b001, 16'h0123, 8'h5A, 1'b0, 1'b0};
    v[1]  = '{16'h0042, 8'hC3, 1'b1, 24'h000000, 2, 3'b010, 16'h0042, 8'h5A, 1'b0, 1'b1};
    v[2]  = '{16'h8000, 8'h00, 1'b0, 24'hFFFFFF, 1, 3'b000, 16'h0000, 8'h00, 1'b1, 1'b0};
    v[3]  = '{16'h0ABC, 8'h00, 1'b0, 24'h0077FF, 2, 3'b010, 16'h0ABC, 8'h77, 1'b0, 1'b0};
    v[4]  = '{16'h9000, 8'h55, 1'b1, 24'h000000, 1, 3'b000, 16'h0000, 8'h77, 1'b1, 1'b0};
    v[5]  = '{16'hBFFF, 8'h00, 1'b0, 24'hA51122, 4, 3'b100, 16'h07FF, 8'hA5, 1'b0, 1'b0};
    v[6]  = '{16'hFFFF, 8'h00, 1'b0, 24'h99883C, 3, 3'b001, 16'h1FFF, 8'h3C, 1'b0, 1'b0};
`ifdef MEMMAP_WPROT_EN
    v[7]  = '{16'hF000, 8'h99, 1'b1, 24'h000000, 3, 3'b001, 16'h1000, 8'h3C, 1'b1, 1'b0};
`else
    v[7]  = '{16'hF000, 8'h99, 1'b1, 24'h000000, 3, 3'b001, 16'h1000, 8'h3C, 1'b0, 1'b1};
`endif
    v[8]  = '{16'h1000, 8'h00, 1'b0, 24'hFFFFFF, 1, 3'b000, 16'h0000, 8'h00, 1'b1, 1'b0};
    v[9]  = '{16'h0FFF, 8'h00, 1'b0, 24'h00EE00, 2, 3'b010, 16'h0FFF, 8'hEE, 1'b0, 1'b0};
    v[10] = '{16'hB7FF, 8'h00, 1'b0, 24'hFFFFFF, 1, 3'b000, 16'h0000, 8'h00, 1'b1, 1'b0};
    v[11] = '{16'hDFFF, 8'h00, 1'b0, 24'hFFFFFF, 1, 3'b000, 16'h0000, 8'h00, 1'b1, 1'b0};

    bus.cpu_req = 1'b0;
    bus.cpu_a   = '0;
    bus.cpu_o   = '0;
    bus.cpu_w   = 1'b0;
    bus.dev_q   = '0;

    // Reset state
    step();
    step();
    check("rst_sel",   bus.dev_sel,   0);
    check("rst_ready", bus.cpu_ready, 0);
    check("rst_err",   bus.bus_err,   0);
    check("rst_we",    bus.dev_we,    0);
    check("rst_a",     bus.dev_a,     0);
    check("rst_d",     bus.dev_d,     0);
    check("rst_i",     bus.cpu_i,     0);
    rst = 1'b0;
    step();

    // Table-driven single accesses
    for (int k = 0; k < 12; k++) begin
      bus.cpu_req = 1'b1;
      bus.cpu_a   = v[k].a;
      bus.cpu_o   = v[k].o;
      bus.cpu_w   = v[k].w;
      bus.dev_q   = v[k].q;
      step();
      // Scramble the CPU bus so only latched values can satisfy the checks
      bus.cpu_req = 1'b0;
      bus.cpu_a   = ~v[k].a;
      bus.cpu_o   = ~v[k].o;
      for (int c = 1; c < v[k].lat; c++) begin
        check($sformatf("v%0d_c%0d_sel", k, c),   bus.dev_sel,   v[k].sel);
        check($sformatf("v%0d_c%0d_a", k, c),     bus.dev_a,     v[k].ea);
        check($sformatf("v%0d_c%0d_ready", k, c), bus.cpu_ready, 0);
        check($sformatf("v%0d_c%0d_we", k, c),    bus.dev_we,
              (c == v[k].lat - 1) ? v[k].we : 1'b0);
        if (v[k].w) begin
          check($sformatf("v%0d_c%0d_d", k, c), bus.dev_d, v[k].o);
        end
        step();
      end
      check($sformatf("v%0d_ready", k), bus.cpu_ready, 1);
      check($sformatf("v%0d_err", k),   bus.bus_err,   v[k].err);
      check($sformatf("v%0d_i", k),     bus.cpu_i,     v[k].ei);
      check($sformatf("v%0d_dsel", k),  bus.dev_sel,   0);
      check($sformatf("v%0d_dwe", k),   bus.dev_we,    0);
      step();
      check($sformatf("v%0d_idle_ready", k), bus.cpu_ready, 0);
      check($sformatf("v%0d_idle_err", k),   bus.bus_err,   0);
    end

    // Request held high: ready at N+4, next access accepted at N+5
    bus.cpu_req = 1'b1;
    bus.cpu_a   = 16'hB805;
    bus.cpu_w   = 1'b0;
    bus.dev_q   = 24'hC40000;
    step();                                      // N+1
    check("hold_sel1",  bus.dev_sel, 3'b100);
    check("hold_a1",    bus.dev_a,   16'h0005);
    step();
    step();                                      // N+3
    check("hold_ready3", bus.cpu_ready, 0);
    check("hold_sel3",   bus.dev_sel,   3'b100);
    step();                                      // N+4
    check("hold_ready4", bus.cpu_ready, 1);
    check("hold_i4",     bus.cpu_i,     8'hC4);
    check("hold_err4",   bus.bus_err,   0);
    step();                                      // N+5
    check("hold_ready5", bus.cpu_ready, 0);
    check("hold_sel5",   bus.dev_sel,   0);
    step();                                      // N+6
    check("hold_sel6",   bus.dev_sel,   3'b100);
    bus.cpu_req = 1'b0;
    bus.dev_q   = 24'h3B0000;
    step();
    step();                                      // N+8
    check("hold_ready8", bus.cpu_ready, 0);
    step();                                      // N+9
    check("hold_ready9", bus.cpu_ready, 1);
    check("hold_i9",     bus.cpu_i,     8'h3B);
    step();

    // Reset in the middle of a WS=2 write
    bus.cpu_req = 1'b1;
    bus.cpu_a   = 16'hB812;
    bus.cpu_o   = 8'h6E;
    bus.cpu_w   = 1'b1;
    step();                                      // N+1
    bus.cpu_req = 1'b0;
    check("abort_sel1", bus.dev_sel, 3'b100);
    check("abort_d1",   bus.dev_d,   8'h6E);
    step();                                      // N+2
    rst = 1'b1;
    #1;
    check("abort_sel",   bus.dev_sel,   0);
    check("abort_a",     bus.dev_a,     0);
    check("abort_d",     bus.dev_d,     0);
    check("abort_we",    bus.dev_we,    0);
    check("abort_ready", bus.cpu_ready, 0);
    check("abort_err",   bus.bus_err,   0);
    check("abort_i",     bus.cpu_i,     0);
    step();
    rst = 1'b0;
    seen_we  = 0;
    seen_rdy = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.dev_we)    seen_we++;
      if (bus.cpu_ready) seen_rdy++;
      step();
    end
    check("abort_no_we",    seen_we,  0);
    check("abort_no_ready", seen_rdy, 0);

    // Fresh read after the aborted access
    bus.cpu_req = 1'b1;
    bus.cpu_a   = 16'hE001;
    bus.cpu_w   = 1'b0;
    bus.dev_q   = 24'h00004D;
    step();                                      // N+1
    bus.cpu_req = 1'b0;
    check("post_sel", bus.dev_sel, 3'b001);
    check("post_a",   bus.dev_a,   16'h0001);
    step();
    step();                                      // N+3
    check("post_ready", bus.cpu_ready, 1);
    check("post_i",     bus.cpu_i,     8'h4D);
    check("post_err",   bus.bus_err,   0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
